// File: rtl/wlmont_iter_ctrl_pkg.sv
// rtl/wlmont_iter_ctrl_pkg.sv - shared types and parameter helpers for the WL Montgomery sequencer
package wlmont_iter_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CORR,
        DONE
    } state_t;

    // Number of W-bit reduction steps needed to consume a LOGQ-bit modulus.
    function automatic int nstep_f(input int logq, input int w);
        return (logq + w - 1) / w;
    endfunction

    // Datapath latency: one extra adder stage once the operand count (m*qH rows
    // plus T>>W plus carry) needs a CSA tree of depth two or more.
    function automatic int dplat_f(input int logq, input int w, input int mullat);
        int rows;
        rows = (((logq - w) < w) ? (logq - w) : w) + 2;
        return (rows >= 4) ? mullat + 1 : mullat;
    endfunction

endpackage

// File: rtl/wlmont_iter_ctrl_if.sv
// rtl/wlmont_iter_ctrl_if.sv - operand/result handshake bundle for the WL Montgomery sequencer
interface wlmont_iter_ctrl_if #(
    parameter int LOGQ = 31,
    parameter int W    = 16
);
    logic [LOGQ-1:0]   q;
    logic [LOGQ-W-1:0] qH;
    logic              in_valid;
    logic              in_ready;
    logic [2*LOGQ-1:0] in_T;
    logic              out_valid;
    logic              out_ready;
    logic [LOGQ-1:0]   out_R;
    logic              busy;

    modport master (
        output q, qH, in_valid, in_T, out_ready,
        input  in_ready, out_valid, out_R, busy
    );

    modport slave (
        input  q, qH, in_valid, in_T, out_ready,
        output in_ready, out_valid, out_R, busy
    );
endinterface

// File: rtl/wlmont_iter_ctrl_sub.sv
// rtl/wlmont_iter_ctrl_sub.sv - one pipelined WL Montgomery step To = (Ti + m*q) >> W
module wlmont_iter_ctrl_sub #(
    parameter int LOGT = 62,
    parameter int LOGQ = 31,
    parameter int W    = 16,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LOGT-1:0]   i_ti,
    input  logic [LOGQ-W-1:0] i_qh,
    output logic [LOGT-1:0]   o_to
);
    // With q = qH*2^W + 1 we have -q^-1 = -1 mod 2^W, so m = -Ti mod 2^W and
    // (Ti + m*q) >> W collapses to (Ti >> W) + m*qH + (Ti[W-1:0] != 0).
    logic [W-1:0]      w_t0;
    logic [LOGT-W-1:0] w_t1;
    logic [W-1:0]      w_m;
    logic [LOGQ-1:0]   w_prod;
    logic [LOGT-1:0]   w_sum;

    logic [LOGQ-1:0]   r_prod;
    logic [LOGT-W-1:0] r_t1;
    logic              r_c;

    assign w_t0   = i_ti[W-1:0];
    assign w_t1   = i_ti[LOGT-1:W];
    assign w_m    = W'(0) - w_t0;
    assign w_prod = LOGQ'(w_m) * LOGQ'(i_qh);

    // Multiply stage: register the partial terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_t1   <= '0;
            r_c    <= 1'b0;
        end else begin
            r_prod <= w_prod;
            r_t1   <= w_t1;
            r_c    <= |w_t0;
        end
    end

    assign w_sum = LOGT'(r_t1) + LOGT'(r_prod) + LOGT'(r_c);

    generate
        if (LAT == 1) begin : g_comb_out
            assign o_to = w_sum;
        end else begin : g_pipe_out
            logic [LOGT-1:0] r_pipe [LAT-1];

            // Remaining latency: register the sum, then delay it to total LAT cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT - 1; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_sum;
                    for (int i = 1; i < LAT - 1; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_to = r_pipe[LAT-2];
        end
    endgenerate
endmodule

// File: rtl/wlmont_iter_ctrl.sv
// rtl/wlmont_iter_ctrl.sv - sequences NSTEP WL Montgomery steps plus a final conditional subtract
module wlmont_iter_ctrl
    import wlmont_iter_ctrl_pkg::*;
#(
    parameter int LOGQ   = 31,
    parameter int W      = 16,
    parameter int MULLAT = 1,
    parameter int DPLAT  = dplat_f(LOGQ, W, MULLAT)
) (
    input  logic                clk,
    input  logic                rst_n,
    wlmont_iter_ctrl_if.slave   bus
);
    localparam int NSTEP = nstep_f(LOGQ, W);
    localparam int TW    = 2 * LOGQ;
    localparam int SW    = $clog2(NSTEP + 1);
    localparam int CW    = $clog2(DPLAT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [TW-1:0]     r_acc;
    logic [LOGQ-1:0]   r_q;
    logic [LOGQ-W-1:0] r_qh;
    logic [SW-1:0]     r_step;
    logic [CW-1:0]     r_wcnt;
    logic [LOGQ-1:0]   r_out;
    logic              r_out_valid;

    logic [TW-1:0]     w_to;
    logic [SW-1:0]     w_step_inc;
    logic              w_last_wait;
    logic              w_ge;
    logic [LOGQ:0]     w_diff;

    assign w_step_inc  = r_step + 1'b1;
    assign w_last_wait = (r_wcnt == CW'(DPLAT - 1));
    // acc < 2q after the last step, so LOGQ+1 bits hold the difference without wrap.
    assign w_ge        = (r_acc >= TW'(r_q));
    assign w_diff      = r_acc[LOGQ:0] - {1'b0, r_q};

    wlmont_iter_ctrl_sub #(
        .LOGT (TW),
        .LOGQ (LOGQ),
        .W    (W),
        .LAT  (DPLAT)
    ) u_sub (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ti  (r_acc),
        .i_qh  (r_qh),
        .o_to  (w_to)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next       = r_state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) w_next = ISSUE;
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (w_last_wait) w_next = (w_step_inc == SW'(NSTEP)) ? CORR : ISSUE;
            end
            CORR: w_next = DONE;
            DONE: begin
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, step/wait counters, accumulator update and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_q         <= '0;
            r_qh        <= '0;
            r_step      <= '0;
            r_wcnt      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_acc  <= bus.in_T;
                        r_q    <= bus.q;
                        r_qh   <= bus.qH;
                        r_step <= '0;
                    end
                end
                ISSUE: r_wcnt <= '0;
                WAIT: begin
                    if (w_last_wait) begin
                        r_acc  <= w_to;
                        r_step <= w_step_inc;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                CORR: begin
                    r_out       <= w_ge ? w_diff[LOGQ-1:0] : r_acc[LOGQ-1:0];
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_R     = r_out;
endmodule

// File: tb/tb_wlmont_iter_ctrl.sv
// tb/tb_wlmont_iter_ctrl.sv - directed self-checking bench for wlmont_iter_ctrl
module tb_wlmont_iter_ctrl;
    localparam int LOGQ = 14;
    localparam int W    = 12;
    localparam int Q0   = 12289;
    localparam int Q1   = 8193;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wlmont_iter_ctrl_if #(.LOGQ(LOGQ), .W(W)) bus ();

    wlmont_iter_ctrl #(.LOGQ(LOGQ), .W(W), .MULLAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: T * 2^-24 mod q by 24 exact halvings modulo q.
    function automatic int unsigned mont(input longint unsigned t, input int unsigned qq);
        longint unsigned r;
        r = t % qq;
        repeat (24) r = r[0] ? (r + qq) >> 1 : r >> 1;
        return int'(r);
    endfunction

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 7);
    endtask

    // One full operation; hold cycles keep out_ready low with in_valid pulses.
    task automatic run_op(input logic [27:0] t, input int unsigned qq, input int unsigned expv,
                          input int hold, input string tag);
        bus.q        = 14'(qq);
        bus.qH       = 2'(qq >> 12);
        bus.in_T     = t;
        bus.in_valid = 1'b1;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_in_ready_low"}, bus.in_ready, 0);
        wait_valid(tag);
        chk({tag, "_R"}, bus.out_R, expv);
        chk({tag, "_R_lt_q"}, (bus.out_R < 14'(qq)), 1);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.in_T     = 28'd117440512;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_R"}, bus.out_R, expv);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_drop_valid"}, bus.out_valid, 0);
        chk({tag, "_idle_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [27:0] t;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.q         = 14'(Q0);
        bus.qH        = 2'd3;
        bus.in_valid  = 1'b0;
        bus.in_T      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_R", bus.out_R, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(28'd0,         Q0, 0,  0, "t_zero");
        run_op(28'd16777216,  Q0, 1,  0, "t_r");
        run_op(28'd83886080,  Q0, 5,  0, "t_5r");
        run_op(28'd12289,     Q0, 0,  0, "t_q");
        run_op(28'd251658240, Q0, 15, 0, "t_15r");
        run_op(28'hFFFFFFF,   Q0, mont(64'hFFFFFFF, Q0), 0, "t_max");
        run_op(28'd83886080,  Q0, 5, 20, "t_stall");
        chk("no_queue_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        chk("no_queue_valid", bus.out_valid, 0);

        for (int k = 0; k < 12; k++) begin
            t = 28'($urandom());
            run_op(t, Q0, mont(64'(t), Q0), int'($urandom_range(0, 3)), "t_rand");
        end

        // Reset during WAIT of the second step.
        run_op(28'd251658240, Q0, 15, 0, "pre_rst");
        bus.in_T     = 28'd50331648;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_out_R", bus.out_R, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_no_stale", bus.out_valid, 0);
        run_op(28'd16777216, Q0, 1, 0, "post_rst");

        // Modulus change mid-operation: sampled q is used.
        bus.q        = 14'(Q0);
        bus.qH       = 2'd3;
        bus.in_T     = 28'd200000000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.q  = 14'(Q1);
        bus.qH = 2'd2;
        @(posedge clk); #1;
        begin
            int n;
            n = 2;
            while (bus.out_valid !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("qchg_lat", n, 7);
        end
        chk("qchg_R", bus.out_R, mont(64'd200000000, Q0));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_op(28'd123456789, Q1, mont(64'd123456789, Q1), 0, "q_new");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
